// File: rtl/ifu_fetch_if.sv
// Bus bundle for the instruction fetch unit: memory request side and decode handoff side.
// The master modport is the fetch unit's view; slave is the environment's view.
interface ifu_fetch_if #(
   parameter int ADDR_W  = 8,
   parameter int INSTR_W = 16
);
   logic               imem_req_o;
   logic [ADDR_W-1:0]  imem_addr_o;
   logic               imem_ack_i;
   logic [INSTR_W-1:0] imem_data_i;
   logic               redirect_i;
   logic [ADDR_W-1:0]  redirect_addr_i;
   logic [INSTR_W-1:0] instr_o;
   logic [ADDR_W-1:0]  instr_pc_o;
   logic               instr_valid_o;
   logic               instr_ready_i;

   modport master (
      output imem_req_o, imem_addr_o, instr_o, instr_pc_o, instr_valid_o,
      input  imem_ack_i, imem_data_i, redirect_i, redirect_addr_i, instr_ready_i
   );

   modport slave (
      input  imem_req_o, imem_addr_o, instr_o, instr_pc_o, instr_valid_o,
      output imem_ack_i, imem_data_i, redirect_i, redirect_addr_i, instr_ready_i
   );
endinterface

// File: rtl/ifu_fetch.sv
// Instruction fetch unit: single-outstanding sequential fetch into a small FIFO,
// with redirect flush and discard of the in-flight response.
module ifu_fetch #(
   parameter int ADDR_W  = 8,
   parameter int INSTR_W = 16,
   parameter int DEPTH   = 2
) (
   input  logic       clock,
   input  logic       reset_n,
   ifu_fetch_if.master bus
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH + 1);
   localparam logic [CNT_W-1:0] FULL_C = CNT_W'(DEPTH);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      FETCH   = 2'd1,
      DISCARD = 2'd2
   } state_t;

   state_t             state_q, state_d;
   logic [ADDR_W-1:0]  pc_q, pc_d;
   logic [ADDR_W-1:0]  addr_q, addr_d;
   logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
   logic [CNT_W-1:0]   count_q, count_d;
   logic [INSTR_W-1:0] data_q [DEPTH];
   logic [ADDR_W-1:0]  tag_q  [DEPTH];
   logic               ack_s, push_s, pop_s;

   // FIFO bookkeeping; a redirect wins over any push or pop in the same cycle
   always_comb begin
      ack_s    = bus.imem_ack_i & (state_q != IDLE);
      pop_s    = (count_q != '0) & bus.instr_ready_i & ~bus.redirect_i;
      push_s   = (state_q == FETCH) & ack_s & ~bus.redirect_i;
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      if (bus.redirect_i) begin
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push_s) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
         end else begin
            wr_ptr_d = wr_ptr_q;
         end
         if (pop_s) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
         end else begin
            rd_ptr_d = rd_ptr_q;
         end
         count_d = count_q + CNT_W'(push_s) - CNT_W'(pop_s);
      end
   end

   // Fetch FSM next state and PC
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      case (state_q)
         IDLE: begin
            if (bus.redirect_i) begin
               pc_d    = bus.redirect_addr_i;
               state_d = FETCH;
            end else if (count_d < FULL_C) begin
               state_d = FETCH;
            end else begin
               state_d = IDLE;
            end
         end
         FETCH: begin
            if (bus.redirect_i) begin
               pc_d    = bus.redirect_addr_i;
               state_d = ack_s ? FETCH : DISCARD;
            end else if (ack_s) begin
               pc_d    = pc_q + ADDR_W'(1);
               state_d = (count_d < FULL_C) ? FETCH : IDLE;
            end else begin
               state_d = FETCH;
            end
         end
         DISCARD: begin
            if (bus.redirect_i) begin
               pc_d    = bus.redirect_addr_i;
               state_d = ack_s ? FETCH : DISCARD;
            end else if (ack_s) begin
               state_d = FETCH;
            end else begin
               state_d = DISCARD;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
      // The stale request keeps its original address until its ack arrives
      addr_d = (state_d == DISCARD) ? addr_q : pc_d;
   end

   // Control state registers
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= IDLE;
         pc_q     <= '0;
         addr_q   <= '0;
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         state_q  <= state_d;
         pc_q     <= pc_d;
         addr_q   <= addr_d;
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
      end
   end

   // FIFO storage: instruction word plus the PC it was fetched from
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            data_q[i] <= '0;
            tag_q[i]  <= '0;
         end
      end else if (push_s) begin
         data_q[wr_ptr_q] <= bus.imem_data_i;
         tag_q[wr_ptr_q]  <= pc_q;
      end
   end

   assign bus.imem_req_o    = (state_q != IDLE);
   assign bus.imem_addr_o   = addr_q;
   assign bus.instr_valid_o = (count_q != '0);
   assign bus.instr_o       = data_q[rd_ptr_q];
   assign bus.instr_pc_o    = tag_q[rd_ptr_q];
endmodule

// File: tb/tb_ifu_fetch.sv
// Bench for ifu_fetch: memory responder, expected-stream scoreboard, directed and random phases.
module tb_ifu_fetch;
   localparam int ADDR_W = 8, INSTR_W = 16, DEPTH = 2;

   logic clock = 1'b0;
   logic reset_n;
   ifu_fetch_if #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W)) bus_if ();
   ifu_fetch #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W), .DEPTH(DEPTH)) dut (
      .clock(clock), .reset_n(reset_n), .bus(bus_if)
   );

   always #5 clock = ~clock;

   typedef struct packed { logic [7:0] pc; logic [15:0] instr; } entry_t;
   entry_t     exp_q[$];
   int         n_cmp = 0, n_err = 0;
   int         lat_fixed = 0;
   bit         lat_rand = 1'b0;
   logic [7:0] exp_fetch = 8'h00;
   bit         stale = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Memory: acks a request after cur_lat waiting cycles, data = addr + 0x1000
   initial begin : responder
      int wait_cnt, cur_lat;
      wait_cnt = 0;
      cur_lat  = 0;
      bus_if.imem_ack_i  = 1'b0;
      bus_if.imem_data_i = 16'h0000;
      forever begin
         @(posedge clock); #1;
         if (!reset_n || !bus_if.imem_req_o) begin
            bus_if.imem_ack_i = 1'b0;
            wait_cnt = 0;
            cur_lat  = lat_rand ? int'($urandom_range(0, 3)) : lat_fixed;
         end else if (wait_cnt >= cur_lat) begin
            bus_if.imem_ack_i  = 1'b1;
            bus_if.imem_data_i = 16'h1000 + {8'h00, bus_if.imem_addr_o};
            wait_cnt = 0;
            cur_lat  = lat_rand ? int'($urandom_range(0, 3)) : lat_fixed;
         end else begin
            bus_if.imem_ack_i = 1'b0;
            wait_cnt++;
         end
      end
   end

   // Scoreboard: good acks push expected entries; decode pops are compared in order
   initial begin : monitor
      logic       prev_req, prev_ack, drop;
      logic [7:0] prev_addr;
      entry_t     e;
      prev_req = 1'b0; prev_ack = 1'b0; prev_addr = 8'h00;
      forever begin
         @(negedge clock);
         if (!reset_n) begin
            exp_q.delete();
            exp_fetch = 8'h00;
            stale     = 1'b0;
            prev_req  = 1'b0;
            prev_ack  = 1'b0;
         end else begin
            if (prev_req && !prev_ack) begin
               chk("req_held", 32'(bus_if.imem_req_o), 32'd1);
               chk("addr_stable", 32'(bus_if.imem_addr_o), 32'(prev_addr));
            end
            if (bus_if.instr_valid_o && bus_if.instr_ready_i && !bus_if.redirect_i) begin
               if (exp_q.size() == 0) begin
                  n_cmp++;
                  n_err++;
                  $display("FAIL pop_unexpected: got pc 0x%0h required no valid entry at %0t",
                           bus_if.instr_pc_o, $time);
               end else begin
                  e = exp_q.pop_front();
                  chk("instr_pc", 32'(bus_if.instr_pc_o), 32'(e.pc));
                  chk("instr", 32'(bus_if.instr_o), 32'(e.instr));
               end
            end
            drop = stale || bus_if.redirect_i;
            if (bus_if.imem_req_o && bus_if.imem_ack_i) begin
               if (!drop) begin
                  chk("fetch_addr", 32'(bus_if.imem_addr_o), 32'(exp_fetch));
                  e.pc    = exp_fetch;
                  e.instr = 16'h1000 + {8'h00, exp_fetch};
                  exp_q.push_back(e);
                  exp_fetch = exp_fetch + 8'h01;
               end
               stale = 1'b0;
            end else if (bus_if.imem_req_o && bus_if.redirect_i) begin
               stale = 1'b1;
            end
            if (bus_if.redirect_i) begin
               exp_q.delete();
               exp_fetch = bus_if.redirect_addr_i;
            end
            prev_req  = bus_if.imem_req_o;
            prev_ack  = bus_if.imem_ack_i;
            prev_addr = bus_if.imem_addr_o;
         end
      end
   end

   task automatic do_reset(input bit with_redir, input logic [7:0] tgt);
      @(posedge clock); #2;
      reset_n = 1'b0;
      bus_if.redirect_i = 1'b0;
      repeat (3) @(posedge clock);
      #1;
      reset_n = 1'b1;
      bus_if.redirect_i      = with_redir;
      bus_if.redirect_addr_i = tgt;
      if (with_redir) begin
         @(posedge clock); #1;
         bus_if.redirect_i = 1'b0;
      end
   endtask

   initial begin : watchdog
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin : main
      bit         found;
      logic [7:0] exp_pc;
      reset_n = 1'b1;
      bus_if.redirect_i      = 1'b0;
      bus_if.redirect_addr_i = 8'h00;
      bus_if.instr_ready_i   = 1'b0;
      #1 reset_n = 1'b0;
      repeat (2) @(negedge clock);
      chk("rst_req", 32'(bus_if.imem_req_o), 32'd0);
      chk("rst_addr", 32'(bus_if.imem_addr_o), 32'd0);
      chk("rst_valid", 32'(bus_if.instr_valid_o), 32'd0);
      chk("rst_instr", 32'(bus_if.instr_o), 32'd0);
      chk("rst_pc", 32'(bus_if.instr_pc_o), 32'd0);

      // Zero-wait streaming
      bus_if.instr_ready_i = 1'b1;
      lat_fixed = 0;
      do_reset(1'b0, 8'h00);
      @(negedge clock);
      chk("t1_req_pre_edge", 32'(bus_if.imem_req_o), 32'd0);
      @(negedge clock);
      chk("t1_req_first", 32'(bus_if.imem_req_o), 32'd1);
      chk("t1_addr_first", 32'(bus_if.imem_addr_o), 32'd0);
      chk("t1_valid_early", 32'(bus_if.instr_valid_o), 32'd0);
      @(negedge clock);
      chk("t1_valid_first", 32'(bus_if.instr_valid_o), 32'd1);
      chk("t1_pc_first", 32'(bus_if.instr_pc_o), 32'd0);
      for (int i = 1; i < 6; i++) begin
         @(negedge clock);
         chk("t1_stream_pc", 32'(bus_if.instr_pc_o), 32'(i));
      end

      // Decode stall fills the FIFO, then drains
      bus_if.instr_ready_i = 1'b0;
      do_reset(1'b0, 8'h00);
      repeat (11) @(negedge clock);
      chk("t2_req_low", 32'(bus_if.imem_req_o), 32'd0);
      chk("t2_addr", 32'(bus_if.imem_addr_o), 32'h02);
      chk("t2_valid", 32'(bus_if.instr_valid_o), 32'd1);
      chk("t2_head_pc", 32'(bus_if.instr_pc_o), 32'h00);
      @(posedge clock); #1;
      bus_if.instr_ready_i = 1'b1;
      @(negedge clock);
      chk("t2_req_still_low", 32'(bus_if.imem_req_o), 32'd0);
      @(negedge clock);
      chk("t2_req_rerise", 32'(bus_if.imem_req_o), 32'd1);
      chk("t2_req_addr", 32'(bus_if.imem_addr_o), 32'h02);
      repeat (6) @(negedge clock);

      // Redirect while a slow request is outstanding
      lat_fixed = 3;
      do_reset(1'b0, 8'h00);
      found = 1'b0;
      for (int i = 0; i < 100 && !found; i++) begin
         @(negedge clock);
         if (bus_if.imem_req_o && bus_if.imem_addr_o == 8'h05) found = 1'b1;
      end
      chk("t3_reach_05", 32'(found), 32'd1);
      @(posedge clock); #1;
      bus_if.redirect_i      = 1'b1;
      bus_if.redirect_addr_i = 8'h40;
      @(posedge clock); #1;
      bus_if.redirect_i = 1'b0;
      @(negedge clock);
      chk("t3_addr_held", 32'(bus_if.imem_addr_o), 32'h05);
      chk("t3_req_held", 32'(bus_if.imem_req_o), 32'd1);
      found = 1'b0;
      for (int i = 0; i < 10 && !found; i++) begin
         @(negedge clock);
         if (bus_if.imem_addr_o == 8'h40) found = 1'b1;
      end
      chk("t3_addr_40", 32'(found), 32'd1);
      found = 1'b0;
      for (int i = 0; i < 10 && !found; i++) begin
         @(negedge clock);
         if (bus_if.instr_valid_o) found = 1'b1;
      end
      chk("t3_valid_seen", 32'(found), 32'd1);
      chk("t3_first_pc", 32'(bus_if.instr_pc_o), 32'h40);

      // Redirect coinciding with ack and pop
      lat_fixed = 0;
      do_reset(1'b0, 8'h00);
      repeat (6) @(negedge clock);
      @(posedge clock); #1;
      bus_if.redirect_i      = 1'b1;
      bus_if.redirect_addr_i = 8'h80;
      @(negedge clock);
      chk("t4_pre_valid", 32'(bus_if.instr_valid_o), 32'd1);
      chk("t4_pre_req", 32'(bus_if.imem_req_o), 32'd1);
      @(posedge clock); #1;
      bus_if.redirect_i = 1'b0;
      @(negedge clock);
      chk("t4_valid_flushed", 32'(bus_if.instr_valid_o), 32'd0);
      chk("t4_addr", 32'(bus_if.imem_addr_o), 32'h80);
      repeat (4) @(negedge clock);

      // Start via redirect near the top of the address space
      do_reset(1'b1, 8'hFE);
      @(negedge clock);
      chk("t5_addr", 32'(bus_if.imem_addr_o), 32'hFE);
      exp_pc = 8'hFE;
      for (int i = 0; i < 4; i++) begin
         @(negedge clock);
         chk("t5_wrap_pc", 32'(bus_if.instr_pc_o), 32'(exp_pc));
         exp_pc = exp_pc + 8'h01;
      end

      // Asynchronous reset with a request pending and data buffered
      lat_fixed = 3;
      bus_if.instr_ready_i = 1'b0;
      do_reset(1'b0, 8'h00);
      found = 1'b0;
      for (int i = 0; i < 50 && !found; i++) begin
         @(negedge clock);
         if (bus_if.instr_valid_o && bus_if.imem_req_o) found = 1'b1;
      end
      chk("t6_setup", 32'(found), 32'd1);
      @(posedge clock); #2;
      reset_n = 1'b0;
      #1;
      chk("t6_req", 32'(bus_if.imem_req_o), 32'd0);
      chk("t6_valid", 32'(bus_if.instr_valid_o), 32'd0);
      chk("t6_addr", 32'(bus_if.imem_addr_o), 32'd0);
      repeat (2) @(posedge clock);
      #1;
      reset_n = 1'b1;
      bus_if.instr_ready_i = 1'b1;
      @(negedge clock);
      @(negedge clock);
      chk("t6_restart_req", 32'(bus_if.imem_req_o), 32'd1);
      chk("t6_restart_addr", 32'(bus_if.imem_addr_o), 32'd0);
      repeat (10) @(negedge clock);

      // Random traffic: latency, decode stalls and redirects
      lat_rand = 1'b1;
      do_reset(1'b0, 8'h00);
      for (int cyc = 0; cyc < 4000; cyc++) begin
         @(posedge clock); #1;
         bus_if.instr_ready_i   = ($urandom_range(0, 9) < 7);
         bus_if.redirect_i      = ($urandom_range(0, 39) == 0);
         bus_if.redirect_addr_i = 8'($urandom);
      end
      bus_if.redirect_i    = 1'b0;
      bus_if.instr_ready_i = 1'b1;
      repeat (20) @(negedge clock);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
